// File: rtl/pong_sound_sched_if.sv
// Request/response bundle between the game logic and the shared speaker scheduler.
// The game side drives the request pulses and mute level; the scheduler drives the pin and status.
interface pong_sound_sched_if;
  logic       wall_hit;
  logic       paddle_hit;
  logic       score;
  logic       game_end;
  logic       speaker;
  logic       busy;
  logic [1:0] active;

  modport master (
    output wall_hit,
    output paddle_hit,
    output score,
    output game_end,
    input  speaker,
    input  busy,
    input  active
  );

  modport slave (
    input  wall_hit,
    input  paddle_hit,
    input  score,
    input  game_end,
    output speaker,
    output busy,
    output active
  );
endinterface

// File: rtl/pong_sound_sched.sv
// Single-speaker beep scheduler: latches wall/paddle/score requests, plays them by fixed
// priority (score > paddle > wall) as square-wave tones separated by a silent gap.
module pong_sound_sched #(
  parameter int WALL_HALF   = 28409,
  parameter int PADDLE_HALF = 18939,
  parameter int SCORE_HALF  = 56818,
  parameter int DUR         = 8388607,
  parameter int GAP         = 1000000
) (
  input logic               clk,
  input logic               rst_n,
  pong_sound_sched_if.slave sb
);

  localparam logic [16:0] WALL_HM1   = 17'(WALL_HALF - 1);
  localparam logic [16:0] PADDLE_HM1 = 17'(PADDLE_HALF - 1);
  localparam logic [16:0] SCORE_HM1  = 17'(SCORE_HALF - 1);
  localparam logic [22:0] DUR_M1     = 23'(DUR - 1);
  localparam logic [19:0] GAP_M1     = 20'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Source codes double as priority ranks: 3 score, 2 paddle, 1 wall, 0 none.
  function automatic logic [1:0] top_src(input logic [2:0] p);
    logic [1:0] s;
    if (p[2]) begin
      s = 2'd3;
    end else if (p[1]) begin
      s = 2'd2;
    end else if (p[0]) begin
      s = 2'd1;
    end else begin
      s = 2'd0;
    end
    return s;
  endfunction

  function automatic logic [2:0] src_mask(input logic [1:0] s);
    logic [2:0] m;
    case (s)
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b010;
      2'd3:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [16:0] half_m1(input logic [1:0] s);
    logic [16:0] h;
    case (s)
      2'd2:    h = PADDLE_HM1;
      2'd3:    h = SCORE_HM1;
      default: h = WALL_HM1;
    endcase
    return h;
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  pend_r, pend_s;
  logic [16:0] hc_r, hc_s;
  logic [22:0] dc_r, dc_s;
  logic [19:0] gc_r, gc_s;
  logic        speaker_r, speaker_s;
  logic [1:0]  active_r, active_s;
  logic        busy_r, busy_s;
  logic [2:0]  req_s;
  logic [1:0]  best_s;
  logic        grant_s;

  assign req_s  = {sb.score, sb.paddle_hit, sb.wall_hit};
  assign best_s = top_src(pend_r);

  // Next-state, pending-latch and output computation.
  always_comb begin
    state_s   = state_r;
    pend_s    = pend_r | req_s;
    hc_s      = hc_r;
    dc_s      = dc_r;
    gc_s      = gc_r;
    speaker_s = speaker_r;
    active_s  = active_r;
    busy_s    = busy_r;
    grant_s   = 1'b0;

    if (sb.game_end) begin
      state_s   = ST_IDLE;
      pend_s    = 3'b000;
      hc_s      = 17'd0;
      dc_s      = 23'd0;
      gc_s      = 20'd0;
      speaker_s = 1'b0;
      active_s  = 2'd0;
      busy_s    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (best_s != 2'd0) begin
            grant_s = 1'b1;
          end else begin
            speaker_s = 1'b0;
            active_s  = 2'd0;
            busy_s    = 1'b0;
          end
        end
        ST_PLAY: begin
          // A strictly higher-ranked pending source aborts the current tone outright.
          if (best_s > active_r) begin
            grant_s = 1'b1;
          end else if (dc_r == DUR_M1) begin
            state_s   = ST_GAP;
            speaker_s = 1'b0;
            active_s  = 2'd0;
            hc_s      = 17'd0;
            dc_s      = 23'd0;
            gc_s      = 20'd0;
          end else begin
            dc_s = dc_r + 23'd1;
            if (hc_r == half_m1(active_r)) begin
              hc_s      = 17'd0;
              speaker_s = ~speaker_r;
            end else begin
              hc_s = hc_r + 17'd1;
            end
          end
        end
        ST_GAP: begin
          speaker_s = 1'b0;
          if (gc_r == GAP_M1) begin
            gc_s = 20'd0;
            if (best_s != 2'd0) begin
              grant_s = 1'b1;
            end else begin
              state_s = ST_IDLE;
              busy_s  = 1'b0;
            end
          end else begin
            gc_s = gc_r + 20'd1;
          end
        end
        default: begin
          state_s   = ST_IDLE;
          hc_s      = 17'd0;
          dc_s      = 23'd0;
          gc_s      = 20'd0;
          speaker_s = 1'b0;
          active_s  = 2'd0;
          busy_s    = 1'b0;
        end
      endcase

      // A pulse of the granted source in the grant cycle is absorbed by the grant.
      if (grant_s) begin
        state_s   = ST_PLAY;
        active_s  = best_s;
        busy_s    = 1'b1;
        speaker_s = 1'b0;
        hc_s      = 17'd0;
        dc_s      = 23'd0;
        gc_s      = 20'd0;
        pend_s    = (pend_r | req_s) & ~src_mask(best_s);
      end else begin
        pend_s = pend_r | req_s;
      end
    end
  end

  // State, counter, pending and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pend_r    <= 3'b000;
      hc_r      <= 17'd0;
      dc_r      <= 23'd0;
      gc_r      <= 20'd0;
      speaker_r <= 1'b0;
      active_r  <= 2'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pend_r    <= pend_s;
      hc_r      <= hc_s;
      dc_r      <= dc_s;
      gc_r      <= gc_s;
      speaker_r <= speaker_s;
      active_r  <= active_s;
      busy_r    <= busy_s;
    end
  end

  assign sb.speaker = speaker_r;
  assign sb.busy    = busy_r;
  assign sb.active  = active_r;

endmodule

// File: tb/tb_pong_sound_sched.sv
// Directed self-checking bench for pong_sound_sched with short tone/gap parameters.
module tb_pong_sound_sched;

  localparam int WH = 4;
  localparam int PH = 3;
  localparam int SH = 5;
  localparam int D  = 40;
  localparam int G  = 6;

  logic       clk;
  logic       rst_n;
  int         total;
  int         bad;
  logic [3:0] obs_s;

  pong_sound_sched_if sb();

  pong_sound_sched #(
    .WALL_HALF  (WH),
    .PADDLE_HALF(PH),
    .SCORE_HALF (SH),
    .DUR        (D),
    .GAP        (G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb)
  );

  assign obs_s = {sb.speaker, sb.busy, sb.active};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {speaker, busy, active} j cycles after a grant: tone, then gap, then idle.
  function automatic logic [3:0] tone_exp(input int j, input logic [1:0] code, input int half);
    logic [3:0] e;
    if (j < 0) begin
      e = 4'b0000;
    end else if (j < D) begin
      e = {((j / half) % 2) == 1, 1'b1, code};
    end else if (j < D + G) begin
      e = 4'b0100;
    end else begin
      e = 4'b0000;
    end
    return e;
  endfunction

  task automatic test_reset;
    sb.wall_hit = 1'b0; sb.paddle_hit = 1'b0; sb.score = 1'b0; sb.game_end = 1'b0;
    rst_n = 1'b0;
    tick;
    total++;
    if (obs_s !== 4'b0000) begin bad++; $display("FAIL reset_state got=%b want=0000", obs_s); end
    @(negedge clk);
    rst_n = 1'b1;
    tick; tick;
    total++;
    if (obs_s !== 4'b0000) begin bad++; $display("FAIL reset_idle got=%b want=0000", obs_s); end
  endtask

  task automatic test_single_wall;
    int   tog;
    int   busy_cnt;
    logic prev;
    tog = 0; busy_cnt = 0; prev = 1'b0;
    sb.wall_hit = 1'b1; tick; sb.wall_hit = 1'b0;
    total++;
    if (obs_s !== 4'b0000) begin bad++; $display("FAIL single_latch got=%b want=0000", obs_s); end
    for (int j = 0; j <= 50; j++) begin
      tick;
      total++;
      if (obs_s !== tone_exp(j, 2'd1, WH)) begin
        bad++; $display("FAIL single j=%0d got=%b want=%b", j, obs_s, tone_exp(j, 2'd1, WH));
      end
      if (sb.speaker !== prev) tog++;
      prev = sb.speaker;
      if (sb.busy === 1'b1) busy_cnt++;
    end
    total++;
    if (tog != 10) begin bad++; $display("FAIL single_toggles got=%0d want=10", tog); end
    total++;
    if (busy_cnt != 46) begin bad++; $display("FAIL single_busy got=%0d want=46", busy_cnt); end
  endtask

  task automatic test_dual;
    logic [3:0] e;
    sb.wall_hit = 1'b1; sb.score = 1'b1; tick; sb.wall_hit = 1'b0; sb.score = 1'b0;
    for (int j = 0; j <= 96; j++) begin
      tick;
      e = (j < D + G) ? tone_exp(j, 2'd3, SH) : tone_exp(j - (D + G), 2'd1, WH);
      total++;
      if (obs_s !== e) begin bad++; $display("FAIL dual j=%0d got=%b want=%b", j, obs_s, e); end
    end
  endtask

  task automatic test_preempt;
    sb.wall_hit = 1'b1; tick; sb.wall_hit = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      sb.paddle_hit = (j == 10) ? 1'b1 : 1'b0;
      tick;
      total++;
      if (obs_s !== tone_exp(j, 2'd1, WH)) begin
        bad++; $display("FAIL preempt_wall j=%0d got=%b want=%b", j, obs_s, tone_exp(j, 2'd1, WH));
      end
    end
    sb.paddle_hit = 1'b0;
    for (int k = 0; k <= 55; k++) begin
      tick;
      total++;
      if (obs_s !== tone_exp(k, 2'd2, PH)) begin
        bad++; $display("FAIL preempt_paddle k=%0d got=%b want=%b", k, obs_s, tone_exp(k, 2'd2, PH));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e;
    sb.paddle_hit = 1'b1; tick; sb.paddle_hit = 1'b0;
    for (int k = 0; k <= 99; k++) begin
      sb.wall_hit = (k == 5 || k == 15) ? 1'b1 : 1'b0;
      tick;
      e = (k < D + G) ? tone_exp(k, 2'd2, PH) : tone_exp(k - (D + G), 2'd1, WH);
      total++;
      if (obs_s !== e) begin bad++; $display("FAIL merge k=%0d got=%b want=%b", k, obs_s, e); end
    end
    sb.wall_hit = 1'b0;
  endtask

  task automatic test_game_end;
    sb.wall_hit = 1'b1; tick; sb.wall_hit = 1'b0;
    for (int j = 0; j <= 6; j++) tick;
    sb.score = 1'b1; tick; sb.score = 1'b0;
    total++;
    if (obs_s !== tone_exp(7, 2'd1, WH)) begin
      bad++; $display("FAIL gend_pre got=%b want=%b", obs_s, tone_exp(7, 2'd1, WH));
    end
    sb.game_end = 1'b1;
    tick;
    total++;
    if (obs_s !== 4'b0000) begin bad++; $display("FAIL gend_mute got=%b want=0000", obs_s); end
    sb.wall_hit = 1'b1; tick; sb.wall_hit = 1'b0;
    tick; tick;
    total++;
    if (obs_s !== 4'b0000) begin bad++; $display("FAIL gend_hold got=%b want=0000", obs_s); end
    sb.game_end = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick;
      total++;
      if (obs_s !== 4'b0000) begin bad++; $display("FAIL gend_flush i=%0d got=%b want=0000", i, obs_s); end
    end
  endtask

  task automatic test_async_reset;
    sb.score = 1'b1; tick; sb.score = 1'b0;
    for (int j = 0; j <= 7; j++) tick;
    total++;
    if (obs_s !== tone_exp(7, 2'd3, SH)) begin
      bad++; $display("FAIL arst_pre got=%b want=%b", obs_s, tone_exp(7, 2'd3, SH));
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs_s !== 4'b0000) begin bad++; $display("FAIL arst_async got=%b want=0000", obs_s); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    total++;
    if (obs_s !== 4'b0000) begin bad++; $display("FAIL arst_release got=%b want=0000", obs_s); end
    sb.score = 1'b1; tick; sb.score = 1'b0;
    for (int j = 0; j <= 50; j++) begin
      tick;
      total++;
      if (obs_s !== tone_exp(j, 2'd3, SH)) begin
        bad++; $display("FAIL arst_score j=%0d got=%b want=%b", j, obs_s, tone_exp(j, 2'd3, SH));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_single_wall;
    test_dual;
    test_preempt;
    test_back_to_back;
    test_game_end;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
